// File: rtl/ap_handshake_tracker.sv
// Transaction tracker for one HLS block's ap_* handshake: timestamps accepts, emits one record per completion.
// Optional AP_TRACKER_STALL_CNT_EN adds a done-while-!ap_continue stall counter reported in rec_stall.
module ap_handshake_tracker #(
  parameter int unsigned TS_W      = 32,
  parameter int unsigned ID_W      = 16,
  parameter int unsigned INFLIGHT  = 4,
  parameter int unsigned REC_DEPTH = 16
) (
  input  logic            ap_clk,
  input  logic            ap_rst_n,
  input  logic            ap_start,
  input  logic            ap_ready,
  input  logic            ap_done,
  input  logic            ap_continue,
  input  logic            finish,
  output logic            rec_valid,
  input  logic            rec_ready,
  output logic [ID_W-1:0] rec_id,
  output logic [TS_W-1:0] rec_start_ts,
  output logic [TS_W-1:0] rec_latency,
  output logic [TS_W-1:0] rec_interval,
  output logic [15:0]     rec_stall,
  output logic [15:0]     drop_cnt,
  output logic            err_inflight_ovf,
  output logic            err_orphan_done,
  output logic            drained
);

  localparam int unsigned QA_W = (INFLIGHT > 1) ? $clog2(INFLIGHT) : 1;
  localparam int unsigned QC_W = QA_W + 1;
  localparam int unsigned FA_W = (REC_DEPTH > 1) ? $clog2(REC_DEPTH) : 1;
  localparam int unsigned FC_W = FA_W + 1;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_e;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [TS_W-1:0] start_ts;
    logic [TS_W-1:0] interval;
  } q_entry_t;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [TS_W-1:0]  start_ts;
    logic [TS_W-1:0]  latency;
    logic [TS_W-1:0]  interval;
    logic [CNT_W-1:0] stall;
  } rec_t;

  state_e           state_q, state_d;
  logic [TS_W-1:0]  ts_q, ts_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [TS_W-1:0]  last_ts_q, last_ts_d;
  logic             have_prev_q, have_prev_d;
  logic [QA_W-1:0]  q_rd_q, q_rd_d, q_wr_q, q_wr_d;
  logic [QC_W-1:0]  q_cnt_q, q_cnt_d;
  logic [FA_W-1:0]  f_rd_q, f_rd_d, f_wr_q, f_wr_d;
  logic [FC_W-1:0]  f_cnt_q, f_cnt_d;
  rec_t             out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             ovf_q, ovf_d;
  logic             orphan_q, orphan_d;
  logic             drained_q, drained_d;

  q_entry_t         q_mem_q [INFLIGHT];
  rec_t             f_mem_q [REC_DEPTH];

  logic             acc_c, cmp_c, q_empty_c, q_full_c, bypass_c;
  logic             q_pop_c, q_push_c, rec_make_c;
  logic             f_pop_c, f_load_c, f_room_c, f_wr_c;
  logic [FC_W-1:0]  f_total_c;
  logic [TS_W-1:0]  interval_c;
  q_entry_t         head_c, push_entry_c;
  rec_t             rec_new_c;
  logic [CNT_W-1:0] stall_val_c;

  // Event decode, start queue, record FIFO and FSM next-state
  always_comb begin
    state_d     = state_q;
    ts_d        = ts_q + TS_W'(1);
    id_d        = id_q;
    last_ts_d   = last_ts_q;
    have_prev_d = have_prev_q;
    q_rd_d      = q_rd_q;
    q_wr_d      = q_wr_q;
    f_rd_d      = f_rd_q;
    f_wr_d      = f_wr_q;
    out_d       = out_q;
    out_valid_d = out_valid_q & ~rec_ready;
    drop_d      = drop_q;
    ovf_d       = ovf_q;
    orphan_d    = orphan_q;
    drained_d   = (state_q == S_DONE);

    acc_c      = (state_q == S_RUN) & ap_start & ap_ready;
    cmp_c      = (state_q != S_DONE) & ap_done & ap_continue;
    q_empty_c  = (q_cnt_q == '0);
    q_full_c   = (q_cnt_q == QC_W'(INFLIGHT));
    bypass_c   = acc_c & cmp_c & q_empty_c;
    q_pop_c    = cmp_c & ~q_empty_c;
    q_push_c   = acc_c & ~bypass_c & (~q_full_c | q_pop_c);
    rec_make_c = bypass_c | q_pop_c;
    interval_c = have_prev_q ? (ts_q - last_ts_q) : '0;
    head_c     = q_mem_q[q_rd_q];

    push_entry_c          = '0;
    push_entry_c.id       = id_q;
    push_entry_c.start_ts = ts_q;
    push_entry_c.interval = interval_c;

    rec_new_c       = '0;
    rec_new_c.stall = stall_val_c;
    if (bypass_c) begin
      rec_new_c.id       = id_q;
      rec_new_c.start_ts = ts_q;
      rec_new_c.interval = interval_c;
    end else begin
      rec_new_c.id       = head_c.id;
      rec_new_c.start_ts = head_c.start_ts;
      rec_new_c.latency  = ts_q - head_c.start_ts;
      rec_new_c.interval = head_c.interval;
    end

    if (acc_c) begin
      id_d        = id_q + ID_W'(1);
      last_ts_d   = ts_q;
      have_prev_d = 1'b1;
    end
    if (q_pop_c)  q_rd_d = q_rd_q + QA_W'(1);
    if (q_push_c) q_wr_d = q_wr_q + QA_W'(1);
    q_cnt_d = q_cnt_q + QC_W'(q_push_c) - QC_W'(q_pop_c);

    if (acc_c & q_full_c & ~q_pop_c)   ovf_d    = 1'b1;
    if (cmp_c & q_empty_c & ~acc_c)    orphan_d = 1'b1;

    // Capacity counts the output register, and a same-cycle consumer pop frees a slot
    f_pop_c   = out_valid_q & rec_ready;
    f_total_c = f_cnt_q + FC_W'(out_valid_q);
    f_room_c  = (f_total_c - FC_W'(f_pop_c)) < FC_W'(REC_DEPTH);
    f_wr_c    = rec_make_c & f_room_c;
    f_load_c  = (~out_valid_q | rec_ready) & (f_cnt_q != '0);

    if (rec_make_c & ~f_room_c & (drop_q != '1)) drop_d = drop_q + CNT_W'(1);
    if (f_wr_c) f_wr_d = f_wr_q + FA_W'(1);
    if (f_load_c) begin
      out_d       = f_mem_q[f_rd_q];
      out_valid_d = 1'b1;
      f_rd_d      = f_rd_q + FA_W'(1);
    end
    f_cnt_d = f_cnt_q + FC_W'(f_wr_c) - FC_W'(f_load_c);

    case (state_q)
      S_RUN:   if (finish) state_d = S_DRAIN;
      S_DRAIN: if ((f_cnt_q == '0) && !out_valid_q && q_empty_c && !rec_make_c) state_d = S_DONE;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= S_RUN;
      ts_q        <= '0;
      id_q        <= '0;
      last_ts_q   <= '0;
      have_prev_q <= 1'b0;
      q_rd_q      <= '0;
      q_wr_q      <= '0;
      q_cnt_q     <= '0;
      f_rd_q      <= '0;
      f_wr_q      <= '0;
      f_cnt_q     <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      drop_q      <= '0;
      ovf_q       <= 1'b0;
      orphan_q    <= 1'b0;
      drained_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ts_q        <= ts_d;
      id_q        <= id_d;
      last_ts_q   <= last_ts_d;
      have_prev_q <= have_prev_d;
      q_rd_q      <= q_rd_d;
      q_wr_q      <= q_wr_d;
      q_cnt_q     <= q_cnt_d;
      f_rd_q      <= f_rd_d;
      f_wr_q      <= f_wr_d;
      f_cnt_q     <= f_cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      drop_q      <= drop_d;
      ovf_q       <= ovf_d;
      orphan_q    <= orphan_d;
      drained_q   <= drained_d;
    end
  end

  // Storage arrays need no reset: the pointers and counts define their contents
  always_ff @(posedge ap_clk) begin
    if (q_push_c) q_mem_q[q_wr_q] <= push_entry_c;
    if (f_wr_c)   f_mem_q[f_wr_q] <= rec_new_c;
  end

`ifdef AP_TRACKER_STALL_CNT_EN
  logic [CNT_W-1:0] stall_q, stall_d;

  // Stall cycles of the oldest outstanding transaction, handed to its record on completion
  always_comb begin
    stall_d = stall_q;
    if (cmp_c) begin
      stall_d = '0;
    end else if (ap_done && !ap_continue && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) stall_q <= '0;
    else           stall_q <= stall_d;
  end

  assign stall_val_c = stall_q;
`else
  assign stall_val_c = '0;
`endif

  assign rec_valid        = out_valid_q;
  assign rec_id           = out_q.id;
  assign rec_start_ts     = out_q.start_ts;
  assign rec_latency      = out_q.latency;
  assign rec_interval     = out_q.interval;
  assign rec_stall        = out_q.stall;
  assign drop_cnt         = drop_q;
  assign err_inflight_ovf = ovf_q;
  assign err_orphan_done  = orphan_q;
  assign drained          = drained_q;

endmodule
